// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the M-extension multiply/divide sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  // funct3 encodings of the RV32M operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return ~op[2];
  endfunction

  // MUL low word is sign-agnostic, so treating it as signed is harmless
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: radix-2 shift-add multiply, restoring divide, sign fixup.
// Latency: one bit per step; the result word is combinational from the registers.
// Backpressure: none; the sequencer controls load/step.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [2:0]            op,
  input  logic                  neg,
  input  logic [DATA_WIDTH-1:0] a_mag,
  input  logic [DATA_WIDTH-1:0] b_mag,
  output logic                  mul_early,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int W = DATA_WIDTH;

  // acc: product for multiply; {remainder, quotient/dividend} for divide.
  // mcand: multiplicand shifted left each step, so acc is always at final
  // alignment and a multiply can stop early without a realignment shift.
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] acc_signed;
  logic [W-1:0]   mplier;
  logic [W-1:0]   div_word;
  logic [W-1:0]   rem_sub;
  logic [W:0]     rem_sh;
  logic [2:0]     op_q;
  logic           fits;

  assign rem_sh    = {acc[2*W-1:W], acc[W-1]};
  assign fits      = rem_sh >= {1'b0, mcand[W-1:0]};
  // only used when fits, in which case the true difference is below 2^W
  assign rem_sub   = rem_sh[W-1:0] - mcand[W-1:0];
  assign mul_early = is_mul(op_q) && (mplier[W-1:1] == '0);

  // load operands on accept, then advance one bit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      op_q   <= '0;
    end else if (load) begin
      op_q   <= op;
      mplier <= is_mul(op) ? b_mag : '0;
      mcand  <= {{W{1'b0}}, (is_mul(op) ? a_mag : b_mag)};
      acc    <= is_mul(op) ? '0 : {{W{1'b0}}, a_mag};
    end else if (step) begin
      if (is_mul(op_q)) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        acc <= {(fits ? rem_sub : rem_sh[W-1:0]), acc[W-2:0], fits};
      end
    end
  end

  // products are negated as a full double word before picking a half;
  // quotient and remainder are negated after selection
  assign acc_signed = neg ? -acc : acc;
  assign div_word   = op_q[1] ? acc[2*W-1:W] : acc[W-1:0];

  // pick the architectural result word for the latched op
  always_comb begin
    word = '0;
    if (is_mul(op_q)) begin
      word = (op_q == OP_MUL) ? acc_signed[W-1:0] : acc_signed[2*W-1:W];
    end else begin
      word = neg ? -div_word : div_word;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer beside the EX ALU; MULDIV_EARLY_OUT_EN enables multiply early-out.
// Latency: result_valid 34 cycles after accept (1 for div-by-zero/overflow; multiply early-out >= 3).
// Backpressure: ready_out only in IDLE, valid_in ignored while busy; hold_pipeline stalls the front end.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  input  logic                  flush,
  output logic                  ready_out,
  output logic                  busy,
  output logic                  hold_pipeline,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] CALC  = ST_CALC;
  localparam logic [1:0] FIXUP = ST_FIXUP;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic          neg_r;
  logic [W-1:0]  result_r;

  logic          accept, sign_a, sign_b, res_neg;
  logic          div_zero, div_ovf, special, calc_last, mul_early;
  logic [W-1:0]  a_mag, b_mag, special_word, core_word;

  assign accept   = (state == IDLE) && valid_in && !flush;
  assign sign_a   = is_signed_a(op) && operand_A[W-1];
  assign sign_b   = is_signed_b(op) && operand_B[W-1];
  assign a_mag    = sign_a ? -operand_A : operand_A;
  assign b_mag    = sign_b ? -operand_B : operand_B;
  // REM takes the dividend's sign; DIV and MUL* take the XOR of both
  assign res_neg  = (!is_mul(op) && op[1]) ? sign_a : (sign_a ^ sign_b);

  assign div_zero = !is_mul(op) && (operand_B == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (operand_A == {1'b1, {(W-1){1'b0}}}) && (operand_B == '1);
  assign special  = div_zero || div_ovf;
  assign special_word = div_zero ? (op[1] ? operand_A : '1)
                                 : (op[1] ? '0 : {1'b1, {(W-1){1'b0}}});

`ifdef MULDIV_EARLY_OUT_EN
  assign calc_last = (cnt == CW'(W-1)) || mul_early;
`else
  logic unused_early;
  assign unused_early = mul_early;
  assign calc_last    = (cnt == CW'(W-1));
`endif

  muldiv_iter_core #(.DATA_WIDTH(W)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && !special),
    .step      (state == CALC),
    .op        (op),
    .neg       (neg_r),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .mul_early (mul_early),
    .word      (core_word)
  );

  // next-state: flush overrides everything and returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = special ? DONE : CALC;
      CALC:    if (calc_last) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // state, iteration counter, sign and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      neg_r    <= 1'b0;
      result_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= '0;
        neg_r <= res_neg;
      end else if (state == CALC) begin
        cnt <= cnt + CW'(1);
      end
      if (accept && special) begin
        result_r <= special_word;
      end else if ((state == FIXUP) && !flush) begin
        result_r <= core_word;
      end
    end
  end

  assign ready_out     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign result_valid  = (state == DONE) && !flush;
  assign hold_pipeline = !flush && (((state == IDLE) && valid_in) ||
                                    (state == CALC) || (state == FIXUP));
  assign result        = result_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] operand_A = '0;
  logic [W-1:0] operand_B = '0;
  logic         ready_out, busy, hold_pipeline, result_valid;
  logic [W-1:0] result;

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .op            (op),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .flush         (flush),
    .ready_out     (ready_out),
    .busy          (busy),
    .hold_pipeline (hold_pipeline),
    .result_valid  (result_valid),
    .result        (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           at;
    string        name;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // cycles from accept to result_valid for a multiply of the given multiplier magnitude
  function automatic int mul_lat(input logic [W-1:0] mag);
`ifdef MULDIV_EARLY_OUT_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
    return n + 2;
`else
    return W + 2;
`endif
  endfunction

  // drive one request in an IDLE cycle; returns at the following negedge (+1)
  task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                       input bit push, output int t0);
    @(negedge clk);
    valid_in  = 1'b1;
    op        = o;
    operand_A = a;
    operand_B = b;
    t0 = cyc;
    if (push) sb.push_back('{exp, t0 + lat, name});
    #1;
    check({name, "_ready"}, W'(ready_out), W'(1));
    check({name, "_hold_accept"}, W'(hold_pipeline), W'(1));
    @(negedge clk);
    valid_in = 1'b0;
    #1;
  endtask

  // count hold_pipeline cycles until the sequencer is back in IDLE
  task automatic wait_idle(input string name, output int hc);
    bit done = 0;
    hc = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (ready_out) done = 1;
      else begin
        if (hold_pipeline) hc++;
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: ready_out still low after 200 cycles, required high", name);
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int t0, hc;
    issue(name, o, a, b, exp, lat, 1'b1, t0);
    wait_idle(name, hc);
    check({name, "_hold_cycles"}, W'(hc + 1), W'(lat));
  endtask

  initial begin
    int t0, hc;
    exp_t e;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", W'(ready_out), W'(1));
    check("rst_busy", W'(busy), W'(0));
    check("rst_hold", W'(hold_pipeline), W'(0));
    check("rst_valid", W'(result_valid), W'(0));
    check("rst_result", result, '0);
    rst_n = 1'b1;

    // scoreboard monitor: every result_valid must match the oldest expectation
    fork
      forever begin
        @(negedge clk);
        #1;
        if (rst_n && result_valid) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: result_valid with %h at cycle %0d, required none", result, cyc);
          end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_cycle"}, W'(cyc), W'(e.at));
            check({e.name, "_hold_done"}, W'(hold_pipeline), W'(0));
          end
        end
      end
    join_none

    run("mul_neg",   3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, mul_lat(32'd3));
    run("mulh_min",  3'b001, 32'h80000000,  32'h80000000, 32'h40000000, mul_lat(32'h80000000));
    run("mulhu_big", 3'b011, 32'h80000000,  32'h80000000, 32'h40000000, mul_lat(32'h80000000));
    run("mulhsu",    3'b010, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, mul_lat(32'd2));
    run("div_neg",   3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, W + 2);
    run("rem_neg",   3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, W + 2);
    run("divu",      3'b101, 32'd100,       32'd7,        32'd14,       W + 2);
    run("remu",      3'b111, 32'd100,       32'd7,        32'd2,        W + 2);
    run("divu_zero", 3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1);
    run("rem_zero",  3'b110, 32'd5,         32'd0,        32'd5,        1);
    run("div_ovf",   3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf",   3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1);
    run("mul_by_one", 3'b000, 32'd9,        32'd1,        32'd9,        mul_lat(32'd1));

    // flushed divide must never produce a result
    issue("div_flushed", 3'b100, 32'd100, 32'd7, '0, 0, 1'b0, t0);
    while (cyc < t0 + 10) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_hold_drop", W'(hold_pipeline), W'(0));
    check("flush_no_valid", W'(result_valid), W'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ready", W'(ready_out), W'(1));
    check("flush_busy", W'(busy), W'(0));

    // new multiply right after flush, with a stray request while busy
    issue("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, mul_lat(32'd4), 1'b1, t0);
    @(negedge clk);
    @(negedge clk);
    valid_in  = 1'b1;
    op        = 3'b111;
    operand_A = 32'd55;
    operand_B = 32'd3;
    #1;
    check("busy_ignores_valid", W'(ready_out), W'(0));
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    wait_idle("mul_after_flush", hc);

    // asynchronous reset mid-multiply aborts with no result
    issue("mul_reset", 3'b000, 32'h1234, 32'h80000010, '0, 0, 1'b0, t0);
    while (cyc < t0 + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ready", W'(ready_out), W'(1));
    check("arst_busy", W'(busy), W'(0));
    check("arst_hold", W'(hold_pipeline), W'(0));
    check("arst_valid", W'(result_valid), W'(0));
    check("arst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("post_rst_ready", W'(ready_out), W'(1));

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", W'(sb.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle sequencer for the RV32IM M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that sit beside the single-cycle ALU in EX.
- Accepts one operation per handshake and runs it with an iterative radix-2 shift-add / restoring-divide datapath.
- Drives hold_pipeline to stall the front end while busy.
- Returns a one-cycle result_valid pulse with the 32-bit result.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
valid_in  input  1  operation request from EX
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_A  input  DATA_WIDTH  rs1 value
operand_B  input  DATA_WIDTH  rs2 value
flush  input  1  abort in-flight op (branch/JALR redirect)
ready_out  output  1  high in IDLE; request accepted when valid_in && ready_out
busy  output  1  high from cycle after accept until DONE inclusive
hold_pipeline  output  1  stall request to the pipeline
result_valid  output  1  one-cycle pulse, result is valid
result  output  DATA_WIDTH  product word or quotient/remainder

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset: state=IDLE; all registers 0. Outputs ready_out=1, busy=0, hold_pipeline=0, result_valid=0, result=0. Asserting rst_n low mid-operation aborts the op immediately with no result.
- State IDLE:
  - On accept, latch op and the operand magnitudes (abs of signed operands per op). Record result sign: MUL* = sign of product; DIV = signA^signB; REM = signA.
  - Special cases go to DONE instead of CALC:
    - Divide by zero: quotient = all ones, remainder = operand_A.
    - Signed overflow, DIV/REM of 0x80000000 by -1: quotient = 0x80000000, remainder = 0.
- State CALC:
  - DATA_WIDTH iterations, one bit per cycle. Multiply uses a 2*DATA_WIDTH accumulator; divide uses restoring shift-subtract.
  - Iteration counter counts 0..DATA_WIDTH-1; leave CALC after count DATA_WIDTH-1.
- State FIXUP: one cycle.
  - Apply two's-complement negation if result sign is set.
  - Select the word: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV*, remainder for REM*.
- State DONE: result_valid=1 for exactly one cycle, result registered and held until the next DONE; return to IDLE.
- Latency (accept edge = cycle 0):
  - Normal op: result_valid in cycle DATA_WIDTH+2 (34).
  - Special case: result_valid in cycle 1.
- hold_pipeline: combinationally high in IDLE when valid_in is high (accept cycle), and high in CALC and FIXUP. Low in DONE, so the pipeline consumes result in DONE.
- valid_in while busy: ignored; no queueing.
- flush:
  - In CALC/FIXUP/DONE: next state IDLE, no result_valid, hold_pipeline drops the same cycle (combinational gate).
  - flush and valid_in in the same IDLE cycle: flush wins, no accept.
- Width rules:
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - All arithmetic is on unsigned magnitudes with sign fixed in FIXUP.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: a multiply leaves CALC as soon as the remaining multiplier shift register is zero, with the accumulator shifted to final alignment. Latency is variable, minimum 3 cycles (e.g. multiplier magnitude 1 gives result_valid in cycle 3). Divide is unchanged.
- Undefined: fixed 34-cycle latency for all non-special ops.

Decomposition:
- Package muldiv_pkg:
  - op_e enum (8 funct3 codes).
  - state_e enum (IDLE, CALC, FIXUP, DONE).
  - DATA_WIDTH default constant.
  - Helper functions is_mul(op), is_signed_a(op), is_signed_b(op).
- Sub-module muldiv_iter_core: pure datapath (accumulator/remainder registers, one-step shift-add/shift-subtract, negate). muldiv_sequencer owns the FSM, counter, handshake and stall.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> result_valid at cycle 34, result 0xFFFFFFEB; hold_pipeline high cycles 0-33, low at 34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0. All four with result_valid at cycle 1.
- Start DIV, pulse flush at cycle 10 -> no result_valid, ready_out=1 at cycle 11, new MUL 3x4 accepted -> 12 at its cycle 34. valid_in pulsed during busy is ignored.
- Drive rst_n low at cycle 20 of a MUL -> all outputs reset values asynchronously, no result_valid after release. With MULDIV_EARLY_OUT_EN: MUL 9 x 1 -> 9 at cycle 3.
